// File: rtl/result_collector_if.sv
// Bundle of the batch-control, core-result and output-stream signals of the
// result collector. The collector uses the master modport; whoever feeds
// cores and sinks results uses the slave modport.
interface result_collector_if #(
  parameter int N     = 4,
  parameter int OUT_W = 32,
  parameter int IDX_W = 2
) ();
  logic                 start;
  logic [N-1:0]         core_done;
  logic [N*OUT_W-1:0]   core_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 busy;
  logic                 batch_done;
  logic                 timeout;

  modport master (
    input  start, core_done, core_value, out_ready,
    output out_valid, out_data, out_idx, out_last, busy, batch_done, timeout
  );

  modport slave (
    output start, core_done, core_value, out_ready,
    input  out_valid, out_data, out_idx, out_last, busy, batch_done, timeout
  );
endinterface

// File: rtl/result_collector.sv
// Collects one prediction per core for a batch (first done per core wins,
// any completion order), then streams the N results out in index order over
// valid/ready. A watchdog forces the drain if some core never reports, in
// which case the missing results read as zero and the sticky timeout is set.
module result_collector #(
  parameter int N       = 4,
  parameter int OUT_W   = 32,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  result_collector_if.master bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t             state_reg;
  state_t             state_next;

  logic [N-1:0]       mask_reg;
  logic [OUT_W-1:0]   res_reg [N];
  logic [TW-1:0]      timer_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               timeout_reg;

  logic               start_ok;
  logic               collecting;
  logic [N-1:0]       new_cap;
  logic               all_done;
  logic               timer_exp;
  logic               accept;
  logic               at_last;

  // Shared decode used by the state machine and the datapath.
  assign start_ok   = (state_reg == S_IDLE) && bus.start;
  assign collecting = (state_reg == S_COLLECT);
  assign new_cap    = collecting ? (bus.core_done & ~mask_reg) : '0;
  assign all_done   = &(mask_reg | new_cap);
  assign timer_exp  = (timer_reg == TIMER_MAX);
  assign accept     = (state_reg == S_DRAIN) && bus.out_ready;
  assign at_last    = (idx_reg == LAST_IDX);

  // Per-core capture slot: a done only lands while the slot is still empty,
  // so later done pulses or value changes from that core are ignored.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_core
      logic             cap_reg;
      logic [OUT_W-1:0] val_reg;

      // Clear on reset or batch start, fill once on the first sampled done.
      always_ff @(posedge clk) begin
        if (rst) begin
          cap_reg <= 1'b0;
          val_reg <= '0;
        end else if (start_ok) begin
          cap_reg <= 1'b0;
          val_reg <= '0;
        end else if (new_cap[gi]) begin
          cap_reg <= 1'b1;
          val_reg <= bus.core_value[gi*OUT_W +: OUT_W];
        end
      end

      assign mask_reg[gi] = cap_reg;
      assign res_reg[gi]  = val_reg;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a completed mask beats a simultaneous watchdog expiry
  // only in the timeout flag, both lead to DRAIN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) state_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (all_done || timer_exp) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (accept && at_last) state_next = S_FINISH;
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Watchdog timer counts COLLECT cycles from zero for each batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg <= '0;
    end else if (start_ok) begin
      timer_reg <= '0;
    end else if (collecting) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // Drain index: zero on entry to DRAIN, advances only on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (start_ok || collecting) begin
      idx_reg <= '0;
    end else if (accept && !at_last) begin
      idx_reg <= idx_reg + 1'b1;
    end
  end

  // Sticky timeout: set only when the watchdog fires with the mask still
  // incomplete after this cycle's captures; cleared by the next batch start.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_reg <= 1'b0;
    end else if (start_ok) begin
      timeout_reg <= 1'b0;
    end else if (collecting && timer_exp && !all_done) begin
      timeout_reg <= 1'b1;
    end
  end

  // Outputs are pure decode of registered state, index and result slots.
  always_comb begin
    bus.out_valid  = (state_reg == S_DRAIN);
    bus.out_idx    = idx_reg;
    bus.out_last   = (state_reg == S_DRAIN) && at_last;
    bus.busy       = (state_reg != S_IDLE);
    bus.batch_done = (state_reg == S_FINISH);
    bus.timeout    = timeout_reg;
    bus.out_data   = '0;
    if (state_reg == S_DRAIN) begin
      for (int i = 0; i < N; i++) begin
        if (idx_reg == IDX_W'(i)) bus.out_data = res_reg[i];
      end
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Table-driven bench for result_collector: each table row describes one
// batch (per-core done cycles and values, backpressure, optional mid-drain
// reset). Expected beats go into a scoreboard queue at stimulus time and are
// popped when the DUT completes a handshake.
module tb_result_collector;

  localparam int N       = 4;
  localparam int OUT_W   = 32;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  result_collector_if #(.N(N), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

  result_collector #(
    .N(N), .OUT_W(OUT_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [N-1:0][7:0]       done_at;   // cycle after start of first done, 0 = never
    logic [N-1:0][OUT_W-1:0] val;
    logic [N-1:0][7:0]       done2_at;  // second done pulse, 0 = none
    logic [N-1:0][OUT_W-1:0] val2;
    logic [7:0]              start_at;  // stray start while busy, 0 = none
    logic [3:0]              rst_beats; // reset after this many beats, 0 = none
    logic                    bp;        // out_ready pattern 1,0,0,...
  } vec_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int beats, bd_cnt, cur_c, last_acc_c;
  bit stall_prev = 1'b0;
  logic [IDX_W-1:0] prev_idx;
  logic [OUT_W-1:0] prev_data;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cur_c, act, exp);
    end
  endtask

  // Evaluate the handshake with the inputs just driven, then advance to the
  // next falling edge.
  task automatic tick();
    beat_t e;
    #1;
    if (stall_prev) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_idx", 32'(bus.out_idx), 32'(prev_idx));
      chk("hold_data", bus.out_data, prev_data);
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    prev_idx   = bus.out_idx;
    prev_data  = bus.out_data;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'(bus.out_idx), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat_idx", 32'(bus.out_idx), 32'(e.idx));
        chk("beat_data", bus.out_data, e.data);
        chk("beat_last", 32'(bus.out_last), 32'(e.last));
      end
      beats++;
      last_acc_c = cur_c;
    end
    if (bus.batch_done) bd_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, bus.out_data, 32'd0);
    chk({tag, "_out_idx"}, 32'(bus.out_idx), 32'd0);
    chk({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_batch_done"}, 32'(bus.batch_done), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
  endtask

  task automatic run_batch(input vec_t v);
    beat_t b;
    bit    exp_to;
    int    maxd, first_v, bd_c;
    bit    seen_bd;

    exp_to = 1'b0;
    maxd   = 0;
    for (int i = 0; i < N; i++) begin
      if (v.done_at[i] == 8'd0) exp_to = 1'b1;
      else if (int'(v.done_at[i]) > maxd) maxd = int'(v.done_at[i]);
      b.idx  = IDX_W'(i);
      b.data = (v.done_at[i] != 8'd0) ? v.val[i] : '0;
      b.last = (i == N - 1);
      exp_q.push_back(b);
    end
    beats = 0; bd_cnt = 0; first_v = 0; bd_c = 0; last_acc_c = 0;

    cur_c = 0;
    bus.start     = 1'b1;
    bus.core_done = '0;
    bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0;

    for (int c = 1; c <= 80; c++) begin
      cur_c = c;
      if (v.rst_beats != 4'd0 && beats == int'(v.rst_beats)) begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        bus.core_done = '0;
        tick();
        rst = 1'b0;
        stall_prev = 1'b0;
        exp_q.delete();
        chk_reset_outputs("mid_rst");
        bd_cnt = 0;
        repeat (4) tick();
        chk("no_batch_done_after_rst", 32'(bd_cnt), 32'd0);
        return;
      end
      bus.start = (c == int'(v.start_at));
      for (int i = 0; i < N; i++) begin
        if (c == int'(v.done_at[i])) begin
          bus.core_done[i] = 1'b1;
          bus.core_value[i*OUT_W +: OUT_W] = v.val[i];
        end else if (c == int'(v.done2_at[i])) begin
          bus.core_done[i] = 1'b1;
          bus.core_value[i*OUT_W +: OUT_W] = v.val2[i];
        end else begin
          bus.core_done[i] = 1'b0;
          bus.core_value[i*OUT_W +: OUT_W] = $urandom;
        end
      end
      bus.out_ready = v.bp ? (c % 3 == 1) : 1'b1;
      if (c == 1) begin
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("timeout_cleared", 32'(bus.timeout), 32'd0);
        chk("no_valid_in_collect", 32'(bus.out_valid), 32'd0);
      end
      if (bus.out_valid && first_v == 0) first_v = c;
      seen_bd = bus.batch_done;
      tick();
      if (seen_bd) begin
        bd_c = c;
        break;
      end
    end
    bus.core_done = '0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;

    chk("batch_done_seen", 32'(bd_c != 0), 32'd1);
    chk("first_valid_cycle", 32'(first_v), exp_to ? 32'(TIMEOUT + 1) : 32'(maxd + 1));
    chk("beats_accepted", 32'(beats), 32'(N));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("batch_done_latency", 32'(bd_c), 32'(last_acc_c + 1));
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("timeout_flag", 32'(bus.timeout), 32'(exp_to));
    tick();
    chk("batch_done_count", 32'(bd_cnt), 32'd1);
    chk("timeout_sticky", 32'(bus.timeout), 32'(exp_to));
    exp_q.delete();
  endtask

  function automatic vec_t mk(input int d0, d1, d2, d3,
                              input logic [OUT_W-1:0] v0, v1, v2, v3,
                              input bit bp, input int rst_beats, input int start_at);
    vec_t v;
    v = '0;
    v.done_at[0] = 8'(d0); v.done_at[1] = 8'(d1);
    v.done_at[2] = 8'(d2); v.done_at[3] = 8'(d3);
    v.val[0] = v0; v.val[1] = v1; v.val[2] = v2; v.val[3] = v3;
    v.bp        = bp;
    v.rst_beats = 4'(rst_beats);
    v.start_at  = 8'(start_at);
    return v;
  endfunction

  initial begin
    // In-order completion.
    tbl[0] = mk(5, 6, 7, 8, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 0, 0);
    // Cores 3 and 1 together, then 0, then 2; stray start while collecting.
    tbl[1] = mk(4, 2, 6, 2, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0, 0, 3);
    // Core 2 pulses done twice with a new value; core 0 re-pulses too.
    tbl[2] = mk(3, 3, 2, 3, 32'h10, 32'h20, 32'hAA, 32'h30, 1'b0, 0, 0);
    tbl[2].done2_at[2] = 8'd4; tbl[2].val2[2] = 32'hBB;
    tbl[2].done2_at[0] = 8'd5; tbl[2].val2[0] = 32'hDEAD;
    // Backpressure.
    tbl[3] = mk(1, 1, 1, 1, 32'hC0FFEE00, 32'hC0FFEE01, 32'hC0FFEE02, 32'hC0FFEE03, 1'b1, 0, 0);
    // Watchdog: core 1 never done, core 0 captured on the expiry cycle.
    tbl[4] = mk(16, 0, 9, 9, 32'h4040, 32'h4141, 32'h4242, 32'h4343, 1'b0, 0, 0);
    // Completion on the expiry cycle: no timeout.
    tbl[5] = mk(1, 1, 1, 16, 32'h5050, 32'h5151, 32'h5252, 32'h5353, 1'b0, 0, 0);
    // Timed-out batch reset after two beats.
    tbl[6] = mk(2, 3, 0, 4, 32'h6060, 32'h6161, 32'h6262, 32'h6363, 1'b0, 2, 0);
    // Clean batch after the reset.
    tbl[7] = mk(2, 3, 4, 5, 32'h7070, 32'h7171, 32'h7272, 32'h7373, 1'b1, 0, 0);

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.core_done  = '0;
    bus.core_value = '0;
    bus.out_ready  = 1'b0;
    cur_c          = 0;
    @(negedge clk);
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    for (int t = 0; t < 8; t++) begin
      $display("batch %0d", t);
      run_batch(tbl[t]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
